ccu_req_mux: RTL and testbench
==============================

Name: ccu_req_mux

Overview:
- Upstream arbitration stage for ccu_fsm.
- Collects ACE request streams from NoMstPorts initiating masters and selects one with a round-robin policy.
- Forwards the selected stream to ccu_fsm as a single mst_req_t and returns the ccu_fsm response to that master only.
- Holds the grant for the whole transaction: AR through the last R beat, or AW through the B handshake.

Parameters:
- NoMstPorts, 4, number of initiating master ports (2..16).
- mst_req_t, logic, ACE request struct (ar/aw/w channels, valids, r_ready, b_ready).
- mst_resp_t, logic, ACE response struct (readies, r/b channels, valids).

Ports:
- clk_i  input  1  clock.
- rst_ni  input  1  asynchronous, active-low reset.
- slv_reqs_i  input  [NoMstPorts] x mst_req_t  requests from the initiating masters.
- slv_resps_o  output  [NoMstPorts] x mst_resp_t  responses to the initiating masters.
- ccu_req_o  output  mst_req_t  request to ccu_fsm.
- ccu_resp_i  input  mst_resp_t  response from ccu_fsm.
- busy_o  output  1  high while a grant is held.
- grant_idx_o  output  $clog2(NoMstPorts)  index of the granted port; valid while busy_o is high.

Behaviour:
- Reset values: state IDLE; rr_ptr 0; grant_idx 0; ar_done/aw_done 0; busy_o 0.
- Reset values of data outputs: all fields of ccu_req_o and all slv_resps_o are '0.
- Reset is asynchronous and may occur mid-transaction. The block drops to IDLE immediately and does not finish the in-flight beat.
- A port requests when slv_reqs_i[i].ar_valid | slv_reqs_i[i].aw_valid is high.
- States: IDLE, BUSY_R, BUSY_W.
- IDLE:
  - All outputs are '0; no readies are given to any master.
  - Pick the first requesting port starting at rr_ptr and scanning upward with wrap-around.
  - On the clock edge, register grant_idx.
  - Go to BUSY_R if that port's ar_valid is high; otherwise go to BUSY_W. AR beats AW on the same port.
  - Set rr_ptr to grant_idx+1 mod NoMstPorts.
  - Grant latency is one cycle from the first cycle a request is visible to the first forwarded cycle.
- BUSY_R:
  - ccu_req_o.ar and ccu_req_o.r_ready come from the granted port.
  - ccu_req_o.ar_valid equals the granted port's ar_valid & ~ar_done.
  - ar_done sets on ar_valid & ar_readyccu.
  - The granted port's slv_resps_o takes ar_ready (gated by ~ar_done), r and r_valid from ccu_resp_i.
  - Leave to IDLE on ccu_resp_i.r_valid & ccu_resp_i.r.last & granted r_ready. Clear ar_done.
- BUSY_W:
  - ccu_req_o takes aw, w, w_valid and b_ready from the granted port.
  - aw_valid is gated by ~aw_done; aw_done sets on the AW handshake.
  - The granted port receives aw_ready (gated by ~aw_done), w_ready, b and b_valid.
  - Leave to IDLE on ccu_resp_i.b_valid & granted b_ready. Clear aw_done.
- Non-granted ports see slv_resps_o = '0 in every state, so their requests stall.
- The response path is purely combinational in BUSY; there are no extra register stages.
- At least one IDLE cycle separates back-to-back transactions. This lets ccu_fsm re-enter IDLE and latch a fresh request.
- A request deasserted by its master while in IDLE, before the grant edge, is not granted.
- A request deasserted while BUSY (illegal per AXI) does not abort the transaction. The block still waits for the completion condition.
- A port holding both ar_valid and aw_valid gets BUSY_R first. Its AW is only eligible after the rotation returns to that port; no special priority for the pending AW.
- busy_o = (state != IDLE); grant_idx_o = grant_idx.

Test Plan:
- Single read, NoMstPorts=4: port 2 raises ar_valid with id 0x5 → next cycle busy_o=1 and grant_idx_o=2; ccu_req_o.ar.id=0x5; after the r.last beat the state returns to IDLE; ports 0, 1 and 3 see '0 throughout.
- Round-robin fairness: ports 0, 1 and 3 request AR continuously → grant order 0,1,3,0,1,3; each grant is followed by ≥1 idle cycle.
- Mixed same port: port 1 raises ar_valid and aw_valid together → BUSY_R first; after r.last the rotation proceeds; port 1's AW is served on its next turn, with aw_ready reaching port 1 only.
- Write path: port 3 sends AW addr 0x1000 plus one W beat → aw_valid is forwarded once (aw_done blocks a repeat); w_ready passes through; release happens on the b_valid/b_ready cycle.
- Multi-beat read: a 4-beat R with last on beat 4 → grant is held until beat 4 is accepted; beats 1-3 do not release it; r_ready low on the granted port stalls release.
- Reset mid-BUSY_W: rst_ni pulled low mid-transaction → same cycle all outputs are '0; after release rr_ptr=0, so port 0 wins if all ports request.

Source files
------------

// File: rtl/ccu_req_mux.sv
// Round-robin arbiter in front of ccu_fsm: grants one ACE master per transaction
// and holds the grant from AR to the last R beat, or from AW to the B handshake.
package ccu_req_mux_pkg;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
  } ax_chan_t;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  strb;
    logic        last;
  } w_chan_t;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } r_chan_t;

  typedef struct packed {
    logic [3:0] id;
    logic [1:0] resp;
  } b_chan_t;

  typedef struct packed {
    ax_chan_t ar;
    logic     ar_valid;
    ax_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     r_ready;
    logic     b_ready;
  } ace_req_t;

  typedef struct packed {
    logic    ar_ready;
    logic    aw_ready;
    logic    w_ready;
    r_chan_t r;
    logic    r_valid;
    b_chan_t b;
    logic    b_valid;
  } ace_resp_t;

endpackage

module ccu_req_mux
  import ccu_req_mux_pkg::*;
#(
  parameter int unsigned NoMstPorts = 4,
  parameter type         mst_req_t  = ace_req_t,
  parameter type         mst_resp_t = ace_resp_t
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  mst_req_t  [NoMstPorts-1:0]          slv_reqs_i,
  output mst_resp_t [NoMstPorts-1:0]          slv_resps_o,
  output mst_req_t                            ccu_req_o,
  input  mst_resp_t                           ccu_resp_i,
  output logic                                busy_o,
  output logic [$clog2(NoMstPorts)-1:0]       grant_idx_o
);

  localparam int unsigned IdxW = $clog2(NoMstPorts);
  typedef logic [IdxW-1:0] idx_t;

  typedef enum logic [1:0] {
    IDLE,
    BUSY_R,
    BUSY_W
  } state_e;

  state_e   state_q, state_d;
  idx_t     rr_q, rr_d;
  idx_t     grant_q, grant_d;
  logic     ar_done_q, ar_done_d;
  logic     aw_done_q, aw_done_d;

  logic [NoMstPorts-1:0] req;
  logic                  any_req;
  idx_t                  sel;
  mst_req_t              gnt_req;

  function automatic idx_t wrap(input int unsigned v);
    return idx_t'(v % NoMstPorts);
  endfunction

  always_comb begin
    for (int unsigned i = 0; i < NoMstPorts; i++) begin
      req[i] = slv_reqs_i[i].ar_valid | slv_reqs_i[i].aw_valid;
    end
  end

  // First requester at or above rr_q, wrapping around.
  always_comb begin
    any_req = 1'b0;
    sel     = '0;
    for (int unsigned i = 0; i < NoMstPorts; i++) begin
      if (!any_req && req[wrap(32'(rr_q) + i)]) begin
        any_req = 1'b1;
        sel     = wrap(32'(rr_q) + i);
      end
    end
  end

  assign gnt_req = slv_reqs_i[grant_q];

  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    grant_d     = grant_q;
    ar_done_d   = ar_done_q;
    aw_done_d   = aw_done_q;
    ccu_req_o   = '0;
    slv_resps_o = '0;

    case (state_q)
      IDLE: begin
        if (any_req) begin
          grant_d = sel;
          rr_d    = wrap(32'(sel) + 1);
          state_d = slv_reqs_i[sel].ar_valid ? BUSY_R : BUSY_W;
        end
      end

      BUSY_R: begin
        ccu_req_o.ar       = gnt_req.ar;
        ccu_req_o.ar_valid = gnt_req.ar_valid & ~ar_done_q;
        ccu_req_o.r_ready  = gnt_req.r_ready;
        slv_resps_o[grant_q].ar_ready = ccu_resp_i.ar_ready & ~ar_done_q;
        slv_resps_o[grant_q].r        = ccu_resp_i.r;
        slv_resps_o[grant_q].r_valid  = ccu_resp_i.r_valid;
        if (gnt_req.ar_valid & ~ar_done_q & ccu_resp_i.ar_ready) begin
          ar_done_d = 1'b1;
        end
        if (ccu_resp_i.r_valid & ccu_resp_i.r.last & gnt_req.r_ready) begin
          state_d   = IDLE;
          ar_done_d = 1'b0;
        end
      end

      BUSY_W: begin
        ccu_req_o.aw       = gnt_req.aw;
        ccu_req_o.aw_valid = gnt_req.aw_valid & ~aw_done_q;
        ccu_req_o.w        = gnt_req.w;
        ccu_req_o.w_valid  = gnt_req.w_valid;
        ccu_req_o.b_ready  = gnt_req.b_ready;
        slv_resps_o[grant_q].aw_ready = ccu_resp_i.aw_ready & ~aw_done_q;
        slv_resps_o[grant_q].w_ready  = ccu_resp_i.w_ready;
        slv_resps_o[grant_q].b        = ccu_resp_i.b;
        slv_resps_o[grant_q].b_valid  = ccu_resp_i.b_valid;
        if (gnt_req.aw_valid & ~aw_done_q & ccu_resp_i.aw_ready) begin
          aw_done_d = 1'b1;
        end
        if (ccu_resp_i.b_valid & gnt_req.b_ready) begin
          state_d   = IDLE;
          aw_done_d = 1'b0;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      rr_q      <= '0;
      grant_q   <= '0;
      ar_done_q <= 1'b0;
      aw_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      rr_q      <= rr_d;
      grant_q   <= grant_d;
      ar_done_q <= ar_done_d;
      aw_done_q <= aw_done_d;
    end
  end

  assign busy_o      = (state_q != IDLE);
  assign grant_idx_o = grant_q;

endmodule

// File: tb/tb_ccu_req_mux.sv
// Randomized bench for ccu_req_mux: masters and a ccu_fsm stand-in are modelled here;
// a round-robin order predictor feeds a scoreboard that a negedge monitor drains.
`timescale 1ns/1ps
module tb_ccu_req_mux;
  import ccu_req_mux_pkg::*;

  localparam int N = 4;

  logic                clk = 1'b0;
  logic                rst_ni = 1'b0;
  ace_req_t  [N-1:0]   slv_reqs;
  ace_resp_t [N-1:0]   slv_resps;
  ace_req_t            ccu_req;
  ace_resp_t           ccu_resp;
  logic                busy;
  logic [1:0]          gidx;

  ccu_req_mux #(
    .NoMstPorts (N),
    .mst_req_t  (ace_req_t),
    .mst_resp_t (ace_resp_t)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .slv_reqs_i  (slv_reqs),
    .slv_resps_o (slv_resps),
    .ccu_req_o   (ccu_req),
    .ccu_resp_i  (ccu_resp),
    .busy_o      (busy),
    .grant_idx_o (gidx)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_wr;
    int          port;
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
  } txn_t;

  txn_t rq[N][$];
  txn_t wq[N][$];
  txn_t exp_q[$];
  int   model_ptr = 0;
  int   total = 0;
  int   bad = 0;

  bit ar_sent[N], aw_sent[N], w_sent[N];

  bit          s_r_act, s_rv, s_aw_got, s_w_got, s_bv;
  int          s_beat, s_nbeats;
  logic [3:0]  s_rid, s_bid;
  logic [31:0] s_raddr;

  function automatic logic [31:0] rdata(input logic [31:0] a, input int b);
    return a ^ {16'hbeef, 16'(b)};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic add_rd(input int p, input logic [3:0] id, input logic [31:0] a, input logic [7:0] len);
    txn_t t;
    t.is_wr = 1'b0; t.port = p; t.id = id; t.addr = a; t.len = len;
    rq[p].push_back(t);
  endtask

  task automatic add_wr(input int p, input logic [3:0] id, input logic [31:0] a);
    txn_t t;
    t.is_wr = 1'b1; t.port = p; t.id = id; t.addr = a; t.len = 8'd0;
    wq[p].push_back(t);
  endtask

  // Round-robin order over pending work: reads of a port go before its writes.
  task automatic predict();
    int cr[N], cw[N], ri[N], wi[N];
    int left = 0;
    int p;
    for (int q = 0; q < N; q++) begin
      cr[q] = rq[q].size(); cw[q] = wq[q].size(); ri[q] = 0; wi[q] = 0;
      left += cr[q] + cw[q];
    end
    while (left > 0) begin
      p = model_ptr;
      while (cr[p] + cw[p] == 0) p = (p + 1) % N;
      if (cr[p] > 0) begin exp_q.push_back(rq[p][ri[p]]); ri[p]++; cr[p]--; end
      else begin exp_q.push_back(wq[p][wi[p]]); wi[p]++; cw[p]--; end
      left--;
      model_ptr = (p + 1) % N;
    end
  endtask

  task automatic drive();
    for (int p = 0; p < N; p++) begin
      slv_reqs[p] = '0;
      if (rq[p].size() > 0 && !ar_sent[p]) begin
        slv_reqs[p].ar_valid = 1'b1;
        slv_reqs[p].ar.id    = rq[p][0].id;
        slv_reqs[p].ar.addr  = rq[p][0].addr;
        slv_reqs[p].ar.len   = rq[p][0].len;
      end
      if (wq[p].size() > 0) begin
        if (!aw_sent[p]) begin
          slv_reqs[p].aw_valid = 1'b1;
          slv_reqs[p].aw.id    = wq[p][0].id;
          slv_reqs[p].aw.addr  = wq[p][0].addr;
        end
        if (!w_sent[p]) begin
          slv_reqs[p].w_valid = 1'b1;
          slv_reqs[p].w.data  = wq[p][0].addr ^ 32'h5a5a5a5a;
          slv_reqs[p].w.strb  = 4'hf;
          slv_reqs[p].w.last  = 1'b1;
        end
      end
      slv_reqs[p].r_ready = ($urandom_range(0, 3) != 0);
      slv_reqs[p].b_ready = ($urandom_range(0, 2) != 0);
    end
    ccu_resp = '0;
    ccu_resp.ar_ready = !s_r_act && ($urandom_range(0, 1) != 0);
    ccu_resp.aw_ready = !s_aw_got && ($urandom_range(0, 1) != 0);
    ccu_resp.w_ready  = !s_w_got && ($urandom_range(0, 1) != 0);
    if (s_r_act && !s_rv) s_rv = ($urandom_range(0, 2) != 0);
    ccu_resp.r_valid = s_rv;
    ccu_resp.r.id    = s_rid;
    ccu_resp.r.data  = rdata(s_raddr, s_beat);
    ccu_resp.r.last  = (s_beat == s_nbeats - 1);
    if (s_aw_got && s_w_got) s_bv = 1'b1;
    ccu_resp.b_valid = s_bv;
    ccu_resp.b.id    = s_bid;
  endtask

  task automatic sample();
    if (s_rv && ccu_req.r_ready) begin
      s_rv = 1'b0; s_beat++;
      if (s_beat == s_nbeats) s_r_act = 1'b0;
    end
    if (ccu_req.ar_valid && ccu_resp.ar_ready) begin
      s_r_act = 1'b1; s_beat = 0; s_nbeats = int'(ccu_req.ar.len) + 1;
      s_rid = ccu_req.ar.id; s_raddr = ccu_req.ar.addr;
    end
    if (s_bv && ccu_req.b_ready) begin
      s_bv = 1'b0; s_aw_got = 1'b0; s_w_got = 1'b0;
    end
    if (ccu_req.aw_valid && ccu_resp.aw_ready) begin s_aw_got = 1'b1; s_bid = ccu_req.aw.id; end
    if (ccu_req.w_valid && ccu_resp.w_ready) s_w_got = 1'b1;
    for (int p = 0; p < N; p++) begin
      if (slv_reqs[p].ar_valid && slv_resps[p].ar_ready) ar_sent[p] = 1'b1;
      if (slv_resps[p].r_valid && slv_reqs[p].r_ready && slv_resps[p].r.last && rq[p].size() > 0) begin
        void'(rq[p].pop_front()); ar_sent[p] = 1'b0;
      end
      if (slv_reqs[p].aw_valid && slv_resps[p].aw_ready) aw_sent[p] = 1'b1;
      if (slv_reqs[p].w_valid && slv_resps[p].w_ready) w_sent[p] = 1'b1;
      if (slv_resps[p].b_valid && slv_reqs[p].b_ready && wq[p].size() > 0) begin
        void'(wq[p].pop_front()); aw_sent[p] = 1'b0; w_sent[p] = 1'b0;
      end
    end
  endtask

  function automatic bit all_empty();
    for (int p = 0; p < N; p++) if (rq[p].size() != 0 || wq[p].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  // Entered at posedge+1 with the DUT idle; returns at posedge+1.
  task automatic run_round();
    bit finished = 1'b0;
    predict();
    drive();
    for (int k = 0; k < 3000 && !finished; k++) begin
      @(negedge clk);
      if (k == 0) check("lat_pre", busy, 0);
      if (k == 1) check("lat_grant", busy, 1);
      if (all_empty() && !busy) finished = 1'b1;
      else begin
        sample();
        @(posedge clk); #1;
        drive();
      end
    end
    if (!finished) begin
      total++; bad++;
      $display("FAIL round_timeout: got busy=%0b want all transactions done", busy);
    end
    check("exp_drained", 64'(exp_q.size()), 0);
    @(posedge clk); #1;
  endtask

  // Scoreboard monitor.
  initial begin
    bit          pbusy = 1'b0, pdone = 1'b0, have = 1'b0, done, iso_ok;
    logic [1:0]  pg = '0;
    txn_t        cur;
    int          beat = 0, arc = 0, awc = 0;
    forever begin
      @(negedge clk);
      done = 1'b0;
      if (!rst_ni) begin
        pbusy = 1'b0; pdone = 1'b0; have = 1'b0;
        continue;
      end
      if (pbusy) begin
        if (pdone) check("release", busy, 0);
        else begin
          check("hold_busy", busy, 1);
          check("hold_idx", gidx, pg);
        end
      end
      if (!busy) begin
        check("idle_quiet", |{ccu_req, slv_resps}, 0);
      end else begin
        if (!pbusy) begin
          if (exp_q.size() == 0) begin
            total++; bad++; have = 1'b0;
            $display("FAIL unexpected_grant: got grant %0d want none", gidx);
          end else begin
            cur = exp_q.pop_front(); have = 1'b1;
            beat = 0; arc = 0; awc = 0;
            check("grant_idx", gidx, cur.port);
            if (cur.is_wr) begin
              check("aw_fwd_valid", ccu_req.aw_valid, 1);
              check("aw_fwd_addr", ccu_req.aw.addr, cur.addr);
              check("aw_fwd_id", ccu_req.aw.id, cur.id);
            end else begin
              check("ar_fwd_valid", ccu_req.ar_valid, 1);
              check("ar_fwd_addr", ccu_req.ar.addr, cur.addr);
              check("ar_fwd_id", ccu_req.ar.id, cur.id);
            end
          end
        end
        if (have) begin
          iso_ok = 1'b1;
          for (int p = 0; p < N; p++) if (p != cur.port && |slv_resps[p] !== 1'b0) iso_ok = 1'b0;
          check("isolation", iso_ok, 1);
          if (!cur.is_wr) begin
            check("no_w_in_read", ccu_req.aw_valid | ccu_req.w_valid | ccu_req.b_ready, 0);
            if (ccu_req.ar_valid && ccu_resp.ar_ready) arc++;
            if (slv_resps[cur.port].r_valid && slv_reqs[cur.port].r_ready) begin
              check("r_data", slv_resps[cur.port].r.data, rdata(cur.addr, beat));
              beat++;
            end
            done = ccu_resp.r_valid && ccu_resp.r.last && slv_reqs[cur.port].r_ready;
            if (done) begin
              check("ar_once", 64'(arc), 1);
              check("r_beats", 64'(beat), 64'(int'(cur.len) + 1));
            end
          end else begin
            check("no_r_in_write", ccu_req.ar_valid | ccu_req.r_ready, 0);
            if (ccu_req.aw_valid && ccu_resp.aw_ready) awc++;
            if (ccu_req.w_valid && ccu_resp.w_ready)
              check("w_data", ccu_req.w.data, cur.addr ^ 32'h5a5a5a5a);
            if (slv_resps[cur.port].b_valid && slv_reqs[cur.port].b_ready)
              check("b_id", slv_resps[cur.port].b.id, cur.id);
            done = ccu_resp.b_valid && slv_reqs[cur.port].b_ready;
            if (done) check("aw_once", 64'(awc), 1);
          end
        end
      end
      pbusy = busy; pg = gidx; pdone = done;
    end
  end

  initial begin
    bit got;
    int n;
    drive();
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_gidx", gidx, 0);
    check("rst_outputs", |{ccu_req, slv_resps}, 0);
    @(posedge clk); #1;
    rst_ni = 1'b1;

    add_rd(2, 4'h5, 32'h0000_0040, 8'd0);
    run_round();
    add_rd(0, 4'h1, 32'h0000_0100, 8'd1); add_rd(0, 4'h2, 32'h0000_0110, 8'd0);
    add_rd(1, 4'h3, 32'h0000_0200, 8'd0); add_wr(1, 4'h4, 32'h0000_0210);
    add_rd(3, 4'h6, 32'h0000_0300, 8'd2); add_rd(3, 4'h7, 32'h0000_0310, 8'd0);
    run_round();
    add_wr(3, 4'h9, 32'h0000_1000);
    add_rd(0, 4'ha, 32'h0000_0500, 8'd3);
    run_round();

    for (int r = 0; r < 25; r++) begin
      n = 0;
      for (int p = 0; p < N; p++) begin
        for (int k = $urandom_range(0, 2); k > 0; k--) begin
          add_rd(p, 4'($urandom), $urandom & 32'hffff_fff0, 8'($urandom_range(0, 3))); n++;
        end
        for (int k = $urandom_range(0, 1); k > 0; k--) begin
          add_wr(p, 4'($urandom), $urandom & 32'hffff_fff0); n++;
        end
      end
      if (n == 0) add_wr(r % N, 4'h1, 32'h0000_0800);
      run_round();
    end

    // Asynchronous reset in the middle of a write.
    add_wr(2, 4'h7, 32'h0000_2000);
    predict();
    drive();
    got = 1'b0;
    for (int k = 0; k < 50 && !got; k++) begin
      @(negedge clk);
      if (busy) got = 1'b1;
      else begin sample(); @(posedge clk); #1; drive(); end
    end
    check("rst_mid_reached_busy", got, 1);
    #2 rst_ni = 1'b0;
    #1;
    check("rst_mid_busy", busy, 0);
    check("rst_mid_gidx", gidx, 0);
    check("rst_mid_outputs", |{ccu_req, slv_resps}, 0);
    for (int p = 0; p < N; p++) begin
      rq[p].delete(); wq[p].delete();
      ar_sent[p] = 1'b0; aw_sent[p] = 1'b0; w_sent[p] = 1'b0;
    end
    s_r_act = 1'b0; s_rv = 1'b0; s_aw_got = 1'b0; s_w_got = 1'b0; s_bv = 1'b0; s_beat = 0;
    exp_q.delete();
    model_ptr = 0;
    drive();
    repeat (2) @(posedge clk);
    #1 rst_ni = 1'b1;
    for (int p = 0; p < N; p++) add_rd(p, 4'(p + 8), 32'h0000_3000 + 32'(p * 16), 8'd0);
    run_round();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
